demux1to2_stream: RTL and testbench

Registered 1-to-2 demultiplexer for the SIC-4 datapath: the inverse of the 2-to-1 result mux. It accepts one WIDTH-bit word per cycle on a valid/ready input stream and steers it, according to a per-word select bit, into one of two single-entry output registers (port A or port B), each with its own valid/ready handshake. It sits between the ALU/result path and two consumers, such as register-file write-back and memory store data, and absorbs per-consumer backpressure without losing or duplicating words.

---
 rtl/demux1to2_stream.sv | 142 ++++++++++++++
 tb/tb_demux1to2_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_stream.sv
// demux1to2_stream: registered 1-to-2 stream demultiplexer.
//
// Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it,
// by in_sel, into one of two single-entry output registers (port A, port B).
// Each port has its own valid/ready handshake, so backpressure on one port
// stalls only the input words that select it.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake (in_ready is combinational)
//   in_sel                   0 = port A, 1 = port B
//   in_data                  input word
//   a_valid/a_ready/a_data   port A output stream (registered)
//   b_valid/b_ready/b_data   port B output stream (registered)
//   a_count/b_count          delivered-word counters, 8-bit wrapping
//                            (present only when DEMUX_STATS_EN is defined)
//
// Optional feature macro: DEMUX_STATS_EN

// Single-entry output register with a 2-state EMPTY/FULL FSM.
module demux1to2_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,     // input transfer targeting this port
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,    // consumer takes the word
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A load wins over a drain: refilling in the same cycle as the consumer
  // takes the word keeps the port FULL with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL: begin
        if (load)       state_d = FULL;
        else if (ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Data only changes on load, so it is stable while FULL and keeps the
  // last word after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (load) data_q <= data_in;
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;

endmodule

module demux1to2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
`ifdef DEMUX_STATS_EN
  output logic [7:0]       a_count,
  output logic [7:0]       b_count,
`endif
  output logic [WIDTH-1:0] b_data
);

  localparam int NUM_PORTS = 2;

  // Index 0 = port A, index 1 = port B.
  logic [NUM_PORTS-1:0]            ready_v;
  logic [NUM_PORTS-1:0]            valid_v;
  logic [NUM_PORTS-1:0]            open_v;
  logic [NUM_PORTS-1:0]            load_v;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data_v;
  logic                            in_xfer;

  assign ready_v = {b_ready, a_ready};

  // A port can take a word if it is empty or draining this cycle; in_ready
  // looks only at the selected port.
  assign open_v   = ~valid_v | ready_v;
  assign in_ready = open_v[in_sel];
  assign in_xfer  = in_valid & in_ready;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign load_v[g] = in_xfer & (in_sel == 1'(g));

    demux1to2_port #(.WIDTH(WIDTH)) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_v[g]),
      .data_in (in_data),
      .ready   (ready_v[g]),
      .valid   (valid_v[g]),
      .data    (data_v[g])
    );
  end

  assign a_valid = valid_v[0];
  assign a_data  = data_v[0];
  assign b_valid = valid_v[1];
  assign b_data  = data_v[1];

`ifdef DEMUX_STATS_EN
  logic [NUM_PORTS-1:0][7:0] cnt_q;

  // Counts completed output transfers; wraps naturally at 8 bits.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt_q[g] <= '0;
      else if (valid_v[g] & ready_v[g]) cnt_q[g] <= cnt_q[g] + 8'd1;
    end
  end

  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Testbench for demux1to2_stream: a directed vector table for the handshake
// corner cases, a 256-word stream to B, asynchronous reset mid-operation and
// 1000 random cycles, all checked against per-port scoreboard queues.
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sel;
  logic [7:0] in_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_data, b_data;
`ifdef DEMUX_STATS_EN
  logic [7:0] a_count, b_count;
`endif

  demux1to2_stream #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
`ifdef DEMUX_STATS_EN
    .a_count  (a_count),
    .b_count  (b_count),
`endif
    .b_data   (b_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard: words accepted for a port and not yet delivered.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         cnt_a = 0, cnt_b = 0;

  // Transfers predicted for the current cycle, applied at the next edge.
  logic       acc_m, ta_m, tb_m, sel_m, exp_ready;
  logic [7:0] d_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Apply inputs (called just after a falling edge), then check the DUT
  // against the scoreboard and predict this cycle's transfers.
  task automatic drive(input logic iv, input logic sel, input logic [7:0] d,
                       input logic ar, input logic br);
    in_valid = iv; in_sel = sel; in_data = d; a_ready = ar; b_ready = br;
    #1;
    exp_ready = sel ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("a_data", 32'(a_data), 32'(qa[0]));
    if (qb.size() != 0) chk("b_data", 32'(b_data), 32'(qb[0]));
    acc_m = iv & exp_ready;
    ta_m  = (qa.size() != 0) & ar;
    tb_m  = (qb.size() != 0) & br;
    sel_m = sel;
    d_m   = d;
  endtask

  task automatic tick();
    if (ta_m) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 256; end
    if (tb_m) begin void'(qb.pop_front()); cnt_b = (cnt_b + 1) % 256; end
    if (acc_m) begin
      if (sel_m) qb.push_back(d_m);
      else       qa.push_back(d_m);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_counts(input string nm);
`ifdef DEMUX_STATS_EN
    chk({nm, "_a_count"}, 32'(a_count), 32'(cnt_a));
    chk({nm, "_b_count"}, 32'(b_count), 32'(cnt_b));
`else
    if (nm.len() < 0) $display("unused");
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    rst_n = 1'b0;
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    acc_m = 1'b0; ta_m = 1'b0; tb_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       iv, sel;
    logic [7:0] d;
    logic       ar, br;
    logic       e_rdy, e_av, e_bv;
    logic [7:0] e_ad, e_bd;   // compared only when the matching valid is expected
  } vec_t;

  vec_t vt[13];

  initial begin
    // iv sel data ar br | rdy av bv ad bd
    vt[0]  = '{1, 0, 8'hAA, 1, 1, 1, 0, 0, 8'h00, 8'h00};
    vt[1]  = '{1, 1, 8'hF0, 1, 1, 1, 1, 0, 8'hAA, 8'h00};
    vt[2]  = '{0, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00, 8'hF0};
    vt[3]  = '{0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00};
    vt[4]  = '{1, 0, 8'h11, 0, 1, 1, 0, 0, 8'h00, 8'h00};
    vt[5]  = '{1, 0, 8'h22, 0, 1, 0, 1, 0, 8'h11, 8'h00};
    vt[6]  = '{1, 0, 8'h22, 0, 1, 0, 1, 0, 8'h11, 8'h00};
    vt[7]  = '{1, 1, 8'h33, 0, 1, 1, 1, 0, 8'h11, 8'h00};
    vt[8]  = '{0, 0, 8'h00, 0, 1, 0, 1, 1, 8'h11, 8'h33};
    vt[9]  = '{1, 0, 8'h44, 1, 1, 1, 1, 0, 8'h11, 8'h00};
    vt[10] = '{1, 0, 8'h55, 1, 1, 1, 1, 0, 8'h44, 8'h00};
    vt[11] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h55, 8'h00};
    vt[12] = '{0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00};

    do_reset();
    @(negedge clk);
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_b_valid", 32'(b_valid), 32'h0);
    chk("rst_a_data", 32'(a_data), 32'h0);
    chk("rst_b_data", 32'(b_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk_counts("rst");

    // Directed table: handshake, backpressure, pass-through refill.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].sel, vt[i].d, vt[i].ar, vt[i].br);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_a_valid", i), 32'(a_valid), 32'(vt[i].e_av));
      chk($sformatf("vec%0d_b_valid", i), 32'(b_valid), 32'(vt[i].e_bv));
      if (vt[i].e_av) chk($sformatf("vec%0d_a_data", i), 32'(a_data), 32'(vt[i].e_ad));
      if (vt[i].e_bv) chk($sformatf("vec%0d_b_data", i), 32'(b_data), 32'(vt[i].e_bd));
      tick();
      if (i == 2) begin
`ifdef DEMUX_STATS_EN
        chk("t1_a_count", 32'(a_count), 32'd1);
        chk("t1_b_count", 32'(b_count), 32'd1);
`endif
      end
    end
    chk_counts("table");

    // 256 words to B: counter wraps to 0, order via scoreboard.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 8'(i * 7 + 3), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef DEMUX_STATS_EN
    chk("wrap_b_count", 32'(b_count), 32'd0);
    chk("wrap_a_count", 32'(a_count), 32'd0);
`endif
    chk("wrap_b_empty", 32'(qb.size()), 32'd0);
    tick();

    // Asynchronous reset between edges with both ports FULL.
    drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'h88, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 32'(a_valid), 32'h0);
    chk("arst_b_valid", 32'(b_valid), 32'h0);
    chk("arst_a_data", 32'(a_data), 32'h0);
    chk("arst_b_data", 32'(b_data), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    acc_m = 1'b0; ta_m = 1'b0; tb_m = 1'b0;
    chk_counts("arst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("post_rst_a_valid", 32'(a_valid), 32'h1);
    chk("post_rst_a_data", 32'(a_data), 32'h5A);
    tick();

    // Random traffic; a stalled input word is held stable until accepted.
    begin
      logic hold_iv, hold_sel;
      logic [7:0] hold_d;
      logic stalled;
      stalled = 1'b0; hold_iv = 1'b0; hold_sel = 1'b0; hold_d = '0;
      for (int c = 0; c < 1000; c++) begin
        if (!stalled) begin
          hold_iv  = ($urandom_range(0, 3) != 0);
          hold_sel = 1'($urandom_range(0, 1));
          hold_d   = 8'($urandom);
        end
        drive(hold_iv, hold_sel, hold_d, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        stalled = hold_iv & ~acc_m;
        tick();
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      tick();
    end
    chk("rand_qa_drained", 32'(qa.size()), 32'd0);
    chk("rand_qb_drained", 32'(qb.size()), 32'd0);
    chk_counts("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
